// File: rtl/hadamard_frame_ctrl.sv
// hadamard_frame_ctrl: frames symbols into the Walsh-Hadamard multiplier and streams its chip sums out
module hadamard_frame_ctrl #(
    parameter int M = 8,
    parameter int N = 16,
    parameter int LOGN = 4,
    parameter int TIMEOUT = 32,
    localparam int W = M + LOGN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           mul_start,
    output logic [M*N-1:0] mul_u,
    input  logic           mul_done,
    input  logic [N*W-1:0] mul_y,
    output logic [W-1:0]   m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic           busy,
    output logic           err_timeout
);
    localparam int RW = $clog2(TIMEOUT);
    localparam logic [LOGN:0] FULL = (LOGN+1)'(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N-1);
    localparam logic [RW-1:0] RUN_MAX = RW'(TIMEOUT-2);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HOLD} state_t;

    state_t          state;
    logic [M-1:0]    in_buf [N];
    logic [W-1:0]    out_buf [N];
    logic [LOGN:0]   fill_cnt;
    logic [LOGN-1:0] chip_idx;
    logic [RW-1:0]   run_cnt;
    logic            out_full;
    logic            s_fire;
    logic            m_fire;
    logic            cap_ok;
    logic            capture;

    assign s_ready = fill_cnt < FULL;
    assign s_fire  = s_valid && s_ready;
    assign m_valid = out_full;
    assign m_data  = out_buf[chip_idx];
    assign m_last  = chip_idx == LAST;
    assign m_fire  = m_valid && m_ready;
    assign busy    = state != IDLE || out_full;
    // the output buffer is reusable in the same cycle its last beat leaves, so frames drain without a bubble
    assign cap_ok  = !out_full || (m_fire && m_last);
    assign capture = cap_ok && ((state == RUN && mul_done) || state == HOLD);

    // accepted symbols land in arrival order, slot fill_cnt
    always_ff @(posedge clk) begin
        if (s_fire) in_buf[fill_cnt[LOGN-1:0]] <= s_data;
    end

    // snapshot all chip sums at once so mul is free for the next frame
    always_ff @(posedge clk) begin
        if (capture) for (int i = 0; i < N; i++) out_buf[i] <= mul_y[i*W +: W];
    end

    // core scheduler: operand is loaded on entry to LAUNCH so it is valid alongside the start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            mul_start   <= 1'b0;
            mul_u       <= '0;
            run_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (s_fire) fill_cnt <= fill_cnt + 1'b1;
            case (state)
                IDLE: if (fill_cnt == FULL) begin
                    state     <= LAUNCH;
                    mul_start <= 1'b1;
                    for (int i = 0; i < N; i++) mul_u[i*M +: M] <= in_buf[i];
                end
                LAUNCH: begin
                    fill_cnt <= '0;
                    run_cnt  <= '0;
                    state    <= RUN;
                end
                RUN: if (mul_done) state <= capture ? IDLE : HOLD;
                     else if (run_cnt == RUN_MAX) begin
                         err_timeout <= 1'b1;
                         state       <= IDLE;
                     end else run_cnt <= run_cnt + 1'b1;
                HOLD: if (capture) state <= IDLE;
            endcase
        end
    end

    // output drain: a capture restarts the chip index, the last beat empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full <= 1'b0;
            chip_idx <= '0;
        end else if (capture) begin
            out_full <= 1'b1;
            chip_idx <= '0;
        end else if (m_fire) begin
            chip_idx <= chip_idx + 1'b1;
            if (m_last) out_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hadamard_frame_ctrl.sv
// tb_hadamard_frame_ctrl: directed and randomized frames against a Walsh-Hadamard reference and a behavioural mul
module tb_hadamard_frame_ctrl;
    localparam int M = 8;
    localparam int N = 16;
    localparam int LOGN = 4;
    localparam int TIMEOUT = 32;
    localparam int W = M + LOGN;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [M-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           mul_start;
    logic [M*N-1:0] mul_u;
    logic           mul_done;
    logic [N*W-1:0] mul_y = '0;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic           m_last;
    logic           busy;
    logic           err_timeout;

    int vectors = 0;
    int miscompares = 0;

    logic [M-1:0]   fr [N];
    logic [W-1:0]   exp_q [$];
    logic           rnd_ready = 1'b0;
    logic           mul_broken = 1'b0;
    logic           mul_rdy = 1'b1;
    logic           mbusy = 1'b0;
    int             mcnt = 0;
    logic [M*N-1:0] mu_q = '0;
    int             acc = 0;
    int             pulses = 0;
    logic [M*N-1:0] lock = '0;
    int             bidx = 0;
    logic           stall = 1'b0;
    logic [W-1:0]   sdata = '0;
    logic           slast = 1'b0;

    hadamard_frame_ctrl #(.M(M), .N(N), .LOGN(LOGN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mul_start(mul_start), .mul_u(mul_u), .mul_done(mul_done), .mul_y(mul_y),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // chip k = sum over i of (-1)^popcount(k&i) * u_i
    function automatic logic [N*W-1:0] wht(input logic [M*N-1:0] u);
        logic [N*W-1:0] y;
        int s;
        y = '0;
        for (int k = 0; k < N; k++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s += (($countones(k & i) % 2) ? -1 : 1) * int'($signed(u[i*M +: M]));
            y[k*W +: W] = W'(s);
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [M*N-1:0] obs, input logic [M*N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mul stand-in: ready drops after start, result appears N/2 cycles later, held until next start
    assign mul_done = mul_rdy && !mul_broken;
    always @(posedge clk) begin
        if (mul_start) begin
            mbusy   <= 1'b1;
            mcnt    <= 1;
            mul_rdy <= 1'b0;
            mu_q    <= mul_u;
        end else if (mbusy) begin
            if (mcnt == N/2) begin
                mul_rdy <= 1'b1;
                mbusy   <= 1'b0;
                mul_y   <= wht(mu_q);
            end else mcnt <= mcnt + 1;
        end
    end

    // symbols held in the input buffer; it empties when the frame launches
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 0;
            lock   <= '0;
            pulses <= 0;
        end else if (mul_start) begin
            acc    <= 0;
            lock   <= mul_u;
            pulses <= pulses + 1;
        end else if (s_valid && s_ready) acc <= acc + 1;
    end

    // output scoreboard, stall stability, input flow control and operand stability
    always @(negedge clk) begin
        if (!rst_n) begin
            bidx  <= 0;
            stall <= 1'b0;
        end else begin
            chk("s_ready", s_ready, acc < N);
            if (!mul_start) chk("mul_u_stable", mul_u, lock);
            if (stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, sdata);
                chk("stall_last", m_last, slast);
            end
            if (m_valid && m_ready) begin
                chk("beat_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
                chk("m_last", m_last, bidx == N-1);
                bidx <= (bidx + 1) % N;
            end
            stall <= m_valid && !m_ready;
            sdata <= m_data;
            slast <= m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input bit push);
        logic [M*N-1:0] u;
        logic [N*W-1:0] y;
        logic hs;
        int g;
        for (int i = 0; i < N; i++) begin
            u[i*M +: M] = fr[i];
            s_valid = 1'b1;
            s_data = fr[i];
            g = 0;
            do begin
                hs = s_ready;
                tick();
                g++;
            end while (!hs && g < 200);
            if (!hs) chk("s_accept_timeout", hs, 1);
        end
        if (push) begin
            y = wht(u);
            for (int k = 0; k < N; k++) exp_q.push_back(y[k*W +: W]);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) fr[i] = M'($urandom);
    endtask

    task automatic wait_start();
        int g = 0;
        while (!mul_start && g < 100) begin
            tick();
            g++;
        end
        chk("mul_start_seen", mul_start, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < 600) begin
            tick();
            g++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_u", mul_u, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) fr[i] = 8'd1;
        send_frame(1);
        s_valid = 1'b0;
        wait_start();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 9) chk("latency_before", m_valid, 0);
            if (k == 10) chk("latency_first", m_valid, 1);
        end
        wait_idle();
        chk("start_pulses", pulses, 1);

        for (int i = 0; i < N; i++) fr[i] = '0;
        fr[0] = 8'd5;
        send_frame(1);
        fr[0] = 8'hFD;
        send_frame(1);
        s_valid = 1'b0;
        wait_idle();

        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(1);
        end
        s_valid = 1'b0;
        wait_idle();

        m_ready = 1'b0;
        rand_frame();
        send_frame(1);
        rand_frame();
        send_frame(1);
        s_valid = 1'b0;
        repeat (40) tick();
        chk("hold_busy", busy, 1);
        chk("hold_valid", m_valid, 1);
        chk("hold_chip0", m_data, exp_q[0]);
        m_ready = 1'b1;
        for (int k = 0; k < 2*N; k++) begin
            chk("no_bubble", m_valid, 1);
            tick();
        end
        wait_idle();

        mul_broken = 1'b1;
        rand_frame();
        send_frame(0);
        s_valid = 1'b0;
        wait_start();
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT-1) chk("err_before", err_timeout, 0);
            if (k == TIMEOUT) begin
                chk("err_set", err_timeout, 1);
                chk("err_idle", busy, 0);
            end
        end
        mul_broken = 1'b0;
        rand_frame();
        send_frame(1);
        s_valid = 1'b0;
        wait_idle();
        chk("err_sticky", err_timeout, 1);

        rand_frame();
        send_frame(1);
        s_valid = 1'b0;
        for (int g = 0; g < 100 && !m_valid; g++) tick();
        chk("pre_reset_valid", m_valid, 1);
        repeat (7) tick();
        chk("pre_reset_last", m_last, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_s_ready", s_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_timeout, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rand_frame();
        send_frame(1);
        s_valid = 1'b0;
        wait_idle();

        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(1);
        end
        s_valid = 1'b0;
        repeat (30) tick();
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
